serial_add_sequencer: RTL and testbench

- Bit-serial controller that time-shares one external 1-bit full adder (sum/carry slice driving the LED outputs) to add two WIDTH-bit operands.
- Latches the operands, presents one bit pair plus the running carry to the adder each advance, and collects sum bits into a result register.
- Runs either free-running (one bit per clock) or single-stepped from a push-button input, so each bit can be watched on the LEDs.

---
 rtl/serial_add_if.sv | 35 +++
 rtl/serial_add_sequencer.sv | 103 ++++++++++
 tb/tb_serial_add_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_if.sv
// Bundle between the bit-serial add sequencer and its user: operand/start request,
// push-button step, the external full-adder slice, and the result/status outputs.
interface serial_add_if #(
  parameter int WIDTH = 4
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // start is a request with an implicit ready: it is accepted only while the
  // sequencer is idle (busy=0 and done=0); in any other cycle it is ignored, not queued.
  logic             start;
  logic             step;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;
  logic [IW-1:0]    bit_idx;

  modport slave (
    input  start, step, op_a, op_b, cin, fa_sum, fa_cout,
    output fa_a, fa_b, fa_cin, sum, cout, busy, done, bit_idx
  );

  modport master (
    output start, step, op_a, op_b, cin, fa_sum, fa_cout,
    input  fa_a, fa_b, fa_cin, sum, cout, busy, done, bit_idx
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller: time-shares one external full adder, LSB first,
// advancing every clock or once per debounced-by-sync rising edge of step.
module serial_add_sequencer #(
  parameter int WIDTH     = 4,
  parameter int STEP_MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_if.slave        io,
  output logic [1:0]         dbg_state
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, sum_r;
  logic             carry, cout_r;
  logic [IW-1:0]    idx_r;
  logic             step_s1, step_s2, step_prev;
  logic             advance, last_bit;
  logic             busy_c, done_c;

  // Synchronised step edges exist in every state but only count while in RUN.
  assign advance  = (STEP_MODE == 0) ? 1'b1 : (step_s2 & ~step_prev);
  assign last_bit = (idx_r == IW'(WIDTH - 1));

  always_comb begin
    state_n = state;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state)
      IDLE: if (io.start) state_n = RUN;
      RUN: begin
        busy_c = 1'b1;
        if (advance && last_bit) state_n = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      sum_r     <= '0;
      cout_r    <= 1'b0;
      idx_r     <= '0;
      step_s1   <= 1'b0;
      step_s2   <= 1'b0;
      step_prev <= 1'b0;
    end else begin
      state     <= state_n;
      step_s1   <= io.step;
      step_s2   <= step_s1;
      step_prev <= step_s2;
      case (state)
        IDLE: if (io.start) begin
          a_sh   <= io.op_a;
          b_sh   <= io.op_b;
          carry  <= io.cin;
          sum_r  <= '0;
          cout_r <= 1'b0;
          idx_r  <= '0;
        end
        RUN: if (advance) begin
          sum_r[idx_r] <= io.fa_sum;
          carry        <= io.fa_cout;
          a_sh         <= a_sh >> 1;
          b_sh         <= b_sh >> 1;
          if (last_bit) begin
            cout_r <= io.fa_cout;
            idx_r  <= '0;
          end else begin
            idx_r  <= idx_r + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The adder slice sees live register bits only while running; LEDs stay dark otherwise.
  assign io.fa_a    = (state == RUN) ? a_sh[0] : 1'b0;
  assign io.fa_b    = (state == RUN) ? b_sh[0] : 1'b0;
  assign io.fa_cin  = (state == RUN) ? carry   : 1'b0;
  assign io.sum     = sum_r;
  assign io.cout    = cout_r;
  assign io.busy    = busy_c;
  assign io.done    = done_c;
  assign io.bit_idx = idx_r;
  assign dbg_state  = state;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench: free-running (i0) and single-step (i1) sequencers, each with a
// behavioural full adder, checked against hand-computed results.
module tb_serial_add_sequencer;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] st0, st1;

  int n_checks = 0;
  int n_errors = 0;
  int done1_cnt = 0;
  logic [W:0] exp_q[$];

  serial_add_if #(.WIDTH(W)) i0 ();
  serial_add_if #(.WIDTH(W)) i1 ();

  serial_add_sequencer #(.WIDTH(W), .STEP_MODE(0)) dut0 (.clk(clk), .rst(rst), .io(i0.slave), .dbg_state(st0));
  serial_add_sequencer #(.WIDTH(W), .STEP_MODE(1)) dut1 (.clk(clk), .rst(rst), .io(i1.slave), .dbg_state(st1));

  // Reference full-adder slices
  assign i0.fa_sum  = i0.fa_a ^ i0.fa_b ^ i0.fa_cin;
  assign i0.fa_cout = (i0.fa_a & i0.fa_b) | (i0.fa_cin & (i0.fa_a ^ i0.fa_b));
  assign i1.fa_sum  = i1.fa_a ^ i1.fa_b ^ i1.fa_cin;
  assign i1.fa_cout = (i1.fa_a & i1.fa_b) | (i1.fa_cin & (i1.fa_a ^ i1.fa_b));

  always #5 clk = ~clk;

  always @(negedge clk) if (i1.done) done1_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start0(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    i0.op_a = a; i0.op_b = b; i0.cin = c; i0.start = 1'b1;
    @(negedge clk);
    i0.start = 1'b0;
    i0.op_a = ~a; i0.op_b = ~b; i0.cin = ~c;
  endtask

  task automatic start1(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    i1.op_a = a; i1.op_b = b; i1.cin = c; i1.start = 1'b1;
    @(negedge clk);
    i1.start = 1'b0;
    i1.op_a = ~a; i1.op_b = ~b; i1.cin = ~c;
  endtask

  task automatic press1(input int hi, input int lo);
    i1.step = 1'b1;
    repeat (hi) @(negedge clk);
    i1.step = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic pop_check(input string tag, input logic [W:0] got);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(got), 32'(e));
    end
  endtask

  // Called on the first RUN-cycle negedge; returns on the done-cycle negedge.
  task automatic wait_done0(output int busy_cnt, output logic [7:0] idx_seq, output logic [3:0] cin_seq);
    bit found;
    found = 1'b0; busy_cnt = 0; idx_seq = '0; cin_seq = '0;
    for (int t = 0; t < 20 && !found; t++) begin
      if (i0.busy) begin
        if (busy_cnt < 4) begin
          idx_seq[busy_cnt*2 +: 2] = i0.bit_idx;
          cin_seq[busy_cnt]        = i0.fa_cin;
        end
        busy_cnt++;
      end
      if (i0.done) begin
        found = 1'b1;
        check("done_busy_low", 32'(i0.busy), 32'd0);
        pop_check("result0", {i0.cout, i0.sum});
      end else begin
        @(negedge clk);
      end
    end
    if (!found) check("done0_timeout", 32'd0, 32'd1);
  endtask

  int bc, lat, dcnt;
  logic [7:0] iseq;
  logic [3:0] cseq;

  initial begin
    rst = 1'b1;
    i0.start = 0; i0.step = 0; i0.op_a = 0; i0.op_b = 0; i0.cin = 0;
    i1.start = 0; i1.step = 0; i1.op_a = 0; i1.op_b = 0; i1.cin = 0;
    repeat (3) @(negedge clk);
    check("rst_state0", 32'(st0), 32'd0);
    check("rst_sum0", {i0.cout, i0.sum}, 32'd0);
    check("rst_busy_done0", {i0.busy, i0.done}, 32'd0);
    check("rst_idx0", 32'(i0.bit_idx), 32'd0);
    check("rst_fa0", {i0.fa_a, i0.fa_b, i0.fa_cin}, 32'd0);
    check("rst_state1", 32'(st1), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 0101 + 0011 + 0 = 0_1000; carries into bits 0..3 are 0,1,1,1
    exp_q.push_back(5'b0_1000);
    start0(4'b0101, 4'b0011, 1'b0);
    wait_done0(bc, iseq, cseq);
    check("busy_cycles", 32'(bc), 32'd4);
    check("idx_seq", 32'(iseq), 32'he4);
    check("cin_seq_a", 32'(cseq), 32'b1110);
    @(negedge clk);
    check("done_one_cycle", 32'(i0.done), 32'd0);
    repeat (2) @(negedge clk);
    check("result_hold", {i0.cout, i0.sum}, 32'b0_1000);

    // 1111 + 0001 + 0 = 1_0000
    exp_q.push_back(5'b1_0000);
    start0(4'b1111, 4'b0001, 1'b0);
    wait_done0(bc, iseq, cseq);
    check("busy_cycles_b", 32'(bc), 32'd4);
    @(negedge clk);

    // 1111 + 1111 + 1 = 1_1111 with carry 1 into every bit
    exp_q.push_back(5'b1_1111);
    start0(4'b1111, 4'b1111, 1'b1);
    wait_done0(bc, iseq, cseq);
    check("cin_seq_c", 32'(cseq), 32'b1111);
    @(negedge clk);

    // start re-raised mid-run is ignored, then held through DONE into next IDLE
    exp_q.push_back(5'b0_1000);
    start0(4'b0101, 4'b0011, 1'b0);
    @(negedge clk); @(negedge clk);
    check("ign_idx", 32'(i0.bit_idx), 32'd2);
    i0.op_a = 4'hf; i0.op_b = 4'hf; i0.cin = 1'b1; i0.start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ign_done", 32'(i0.done), 32'd1);
    pop_check("ign_result", {i0.cout, i0.sum});
    @(negedge clk);
    check("held_idle", {30'd0, st0}, 32'd0);
    check("held_idle_busy", 32'(i0.busy), 32'd0);
    exp_q.push_back(5'b1_1111);
    @(negedge clk);
    check("held_run_busy", 32'(i0.busy), 32'd1);
    i0.start = 1'b0;
    wait_done0(bc, iseq, cseq);
    @(negedge clk);

    // reset mid-run at bit 2 (partial sum 0011 so far)
    start0(4'b1001, 4'b0110, 1'b0);
    @(negedge clk); @(negedge clk);
    check("rst_at_idx", 32'(i0.bit_idx), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_state", 32'(st0), 32'd0);
    check("mid_rst_sum", {i0.cout, i0.sum}, 32'd0);
    check("mid_rst_busy", 32'(i0.busy), 32'd0);
    check("mid_rst_idx", 32'(i0.bit_idx), 32'd0);
    dcnt = 0;
    repeat (6) begin
      if (i0.done) dcnt++;
      @(negedge clk);
    end
    check("mid_rst_no_done", 32'(dcnt), 32'd0);
    exp_q.push_back(5'b0_1111);
    start0(4'b1001, 4'b0110, 1'b0);
    wait_done0(bc, iseq, cseq);
    @(negedge clk);

    // single-step: a press in IDLE must not carry over into the next run
    done1_cnt = 0;
    press1(10, 10);
    start1(4'b0101, 4'b0011, 1'b0);
    repeat (5) @(negedge clk);
    check("step_idle_press", 32'(i1.bit_idx), 32'd0);
    check("step_busy", 32'(i1.busy), 32'd1);
    repeat (3) press1(10, 10);
    check("step_idx3", 32'(i1.bit_idx), 32'd3);
    check("step_busy3", 32'(i1.busy), 32'd1);
    check("step_no_done", 32'(done1_cnt), 32'd0);
    i1.step = 1'b1;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (i1.done && lat == 0) lat = n;
    end
    i1.step = 1'b0;
    repeat (10) @(negedge clk);
    check("step_done_lat", 32'((lat >= 2) && (lat <= 3)), 32'd1);
    check("step_done_once", 32'(done1_cnt), 32'd1);
    check("step_result", {i1.cout, i1.sum}, 32'b0_1000);

    // held button: exactly one advance for 50 cycles high
    start1(4'b0001, 4'b0001, 1'b0);
    i1.step = 1'b1;
    repeat (50) @(negedge clk);
    check("step_hold_idx", 32'(i1.bit_idx), 32'd1);
    i1.step = 1'b0;
    repeat (10) @(negedge clk);
    repeat (3) press1(10, 10);
    check("step_hold_done", 32'(done1_cnt), 32'd2);
    check("step_hold_result", {i1.cout, i1.sum}, 32'b0_0010);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
